// File: rtl/nap_timer.sv
// Power-nap countdown: two-digit minute entry from the keypad, MM:SS countdown in
// one-second ticks, then a held alarm_start level until the user acknowledges with stop.
module nap_timer #(
   parameter int TICK_CNT = 1000000,
   parameter int MAX_MIN  = 99
) (
   input  logic       clk,
   input  logic       rst,
   // key_valid is a one-cycle strobe with no back-pressure: key_code is read only
   // in a cycle where key_valid is high, and every strobed key is consumed on that edge.
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       stop,
   output logic       alarm_start,
   output logic       running,
   output logic [6:0] remain_min,
   output logic [5:0] remain_sec,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RING = 2'd2
   } state_t;

   localparam int CW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CNT - 1);
   localparam logic [6:0]    MAX_M     = 7'(MAX_MIN);

   state_t          state, state_n;
   logic [6:0]      set_min, set_min_n;
   logic [6:0]      remain_min_n;
   logic [5:0]      remain_sec_n;
   logic [CW-1:0]   tick_cnt, tick_cnt_n;
   logic            alarm_n, running_n;

   logic            is_digit, is_star, is_sharp, tick;
   logic [7:0]      shifted;
   logic [6:0]      entry_min;

   assign is_digit = key_valid && (key_code <= 4'd9);
   assign is_star  = key_valid && (key_code == 4'd10);
   assign is_sharp = key_valid && (key_code == 4'd11);
   assign tick     = (tick_cnt == TICK_LAST);

   // Shift entry keeps only the newest two digits, then clamps.
   assign shifted   = {1'b0, set_min % 7'd10} * 8'd10 + {4'b0000, key_code};
   assign entry_min = (shifted > {1'b0, MAX_M}) ? MAX_M : shifted[6:0];

   always_comb begin
      state_n      = state;
      set_min_n    = set_min;
      remain_min_n = remain_min;
      remain_sec_n = remain_sec;
      tick_cnt_n   = tick_cnt;
      alarm_n      = alarm_start;
      running_n    = running;
      case (state)
         IDLE: begin
            alarm_n    = 1'b0;
            running_n  = 1'b0;
            tick_cnt_n = '0;
            if (is_digit) begin
               set_min_n = entry_min;
            end else if (is_star) begin
               set_min_n = '0;
            end else if (is_sharp && (set_min != 7'd0)) begin
               state_n      = RUN;
               running_n    = 1'b1;
               remain_min_n = set_min;
               remain_sec_n = '0;
            end
         end
         RUN: begin
            if (is_star) begin
               state_n    = IDLE;
               running_n  = 1'b0;
               tick_cnt_n = '0;
            end else begin
               tick_cnt_n = tick ? '0 : tick_cnt + CW'(1);
               if (tick) begin
                  if (remain_sec != 6'd0) begin
                     remain_sec_n = remain_sec - 6'd1;
                     if ((remain_min == 7'd0) && (remain_sec == 6'd1)) begin
                        state_n   = RING;
                        alarm_n   = 1'b1;
                        running_n = 1'b0;
                     end
                  end else if (remain_min != 7'd0) begin
                     remain_min_n = remain_min - 7'd1;
                     remain_sec_n = 6'd59;
                  end
               end
            end
         end
         RING: begin
            tick_cnt_n   = '0;
            alarm_n      = 1'b1;
            running_n    = 1'b0;
            remain_min_n = '0;
            remain_sec_n = '0;
            if (stop) begin
               state_n = IDLE;
               alarm_n = 1'b0;
            end
         end
         default: begin
            state_n    = IDLE;
            alarm_n    = 1'b0;
            running_n  = 1'b0;
            tick_cnt_n = '0;
         end
      endcase
      // Whenever we are (or land) in IDLE the display shows the entered length.
      if (state_n == IDLE) begin
         remain_min_n = set_min_n;
         remain_sec_n = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         set_min     <= '0;
         remain_min  <= '0;
         remain_sec  <= '0;
         tick_cnt    <= '0;
         alarm_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         state       <= state_n;
         set_min     <= set_min_n;
         remain_min  <= remain_min_n;
         remain_sec  <= remain_sec_n;
         tick_cnt    <= tick_cnt_n;
         alarm_start <= alarm_n;
         running     <= running_n;
      end
   end

   assign dbg_state = state;

endmodule
